// File: rtl/sc_stream_decoder_if.sv
// Handshake/bus bundle for the stochastic stream decoder: sample input side,
// count readout side and an FSM state tap.
interface sc_stream_decoder_if #(
  parameter int N = 16,
  parameter int W = 9
);
  logic           start;
  logic           streamValid;
  logic [N-1:0]   streams;
  logic [N*W-1:0] results;
  logic           resultValid;
  logic           resultReady;
  logic           busy;
  logic [1:0]     state_dbg;

  // Handshake: a window of counts transfers on a cycle where resultValid and
  // resultReady are both high; resultValid stays high and results stay stable
  // until that cycle. Samples have no backpressure: streamValid=1 is a sample.
  modport master (
    output start, streamValid, streams, resultReady,
    input  results, resultValid, busy, state_dbg
  );

  modport slave (
    input  start, streamValid, streams, resultReady,
    output results, resultValid, busy, state_dbg
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Counts the ones of M*O stochastic bitstreams over a window of 2**LENGTH_BITS
// accepted samples and presents the counts through a valid/ready handshake.
module sc_stream_decoder #(
  parameter int BATCH_SIZE      = 4,
  parameter int OUTPUT_FEATURES = 4,
  parameter int LENGTH_BITS     = 8
) (
  input  logic             clk,
  input  logic             rst,
  sc_stream_decoder_if.slave bus
);
  localparam int N = BATCH_SIZE * OUTPUT_FEATURES;
  localparam int W = LENGTH_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           cnt_q [N];
  logic [W-1:0]           cnt_d [N];
  logic [LENGTH_BITS-1:0] samp_q, samp_d;
  logic                   rv_q, rv_d;
  logic                   busy_q, busy_d;
  logic                   samp_last;

  // The sample counter only needs LENGTH_BITS bits: the window ends on the
  // accepted sample seen while it reads all-ones, and it wraps back to zero.
  assign samp_last = bus.streamValid && (samp_q == {LENGTH_BITS{1'b1}});

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    rv_d    = rv_q;
    busy_d  = busy_q;
    for (int k = 0; k < N; k++) cnt_d[k] = cnt_q[k];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          busy_d  = 1'b1;
          samp_d  = '0;
          for (int k = 0; k < N; k++) cnt_d[k] = '0;
        end
      end

      ACCUM: begin
        if (bus.streamValid) begin
          for (int k = 0; k < N; k++) cnt_d[k] = cnt_q[k] + W'(bus.streams[k]);
          samp_d = samp_q + 1'b1;
          if (samp_last) begin
            state_d = HOLD;
            busy_d  = 1'b0;
            rv_d    = 1'b1;
          end
        end
      end

      HOLD: begin
        if (bus.resultReady) begin
          rv_d = 1'b0;
          if (bus.start) begin
            // Back-to-back window: counts restart on the handshake edge.
            state_d = ACCUM;
            busy_d  = 1'b1;
            samp_d  = '0;
            for (int k = 0; k < N; k++) cnt_d[k] = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        rv_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Counts are read straight from the accumulators; they keep the last
  // completed window until the next start clears them.
  for (genvar g = 0; g < N; g++) begin : g_res
    assign bus.results[g*W +: W] = cnt_q[g];
  end

  assign bus.resultValid = rv_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder: window-level model, per-cycle compare,
// per-window expected-count scoreboard and hand-computed literal checks.
module tb_sc_stream_decoder;
  localparam int M   = 4;
  localparam int O   = 4;
  localparam int N   = M * O;
  localparam int L   = 8;
  localparam int W   = L + 1;
  localparam int WIN = 1 << L;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_stream_decoder_if #(.N(N), .W(W)) bus ();

  sc_stream_decoder #(
    .BATCH_SIZE      (M),
    .OUTPUT_FEATURES (O),
    .LENGTH_BITS     (L)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string nm, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // ---------------- window model ----------------
  // phase: 0 waiting for start, 1 collecting samples, 2 window complete
  int m_phase = 0;
  int m_n     = 0;
  int m_cnt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_n     = 0;
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
             m_phase = 1; m_n = 0;
             foreach (m_cnt[k]) m_cnt[k] = 0;
           end
        1: if (bus.streamValid) begin
             foreach (m_cnt[k]) m_cnt[k] += int'(bus.streams[k]);
             m_n++;
             if (m_n == WIN) m_phase = 2;
           end
        2: if (bus.resultReady) begin
             if (bus.start) begin
               m_phase = 1; m_n = 0;
               foreach (m_cnt[k]) m_cnt[k] = 0;
             end else begin
               m_phase = 0;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  int prev_phase = 0;
  logic [N*W-1:0] ev;
  logic [W-1:0]   sb_e;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) ev[k*W +: W] = W'(m_cnt[k]);
    check("results", bus.results, ev);
    check("resultValid", bus.resultValid, m_phase == 2);
    check("busy", bus.busy, m_phase == 1);
    if (m_phase == 2 && prev_phase != 2) begin
      for (int k = 0; k < N; k++) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty t=%0t got=window exp=no window", $time);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_count", bus.results[k*W +: W], sb_e);
        end
      end
    end
    prev_phase = m_phase;
  end

  // ---------------- stimulus helpers ----------------
  // Hand-derived counts for each pattern over a 256-sample window.
  function automatic int exp_count(input int p, input int k);
    if (p == 0)  return WIN;
    if (k == 0)  return 128;
    if (k == 1)  return 0;
    if (k == 15) return 64;
    return (WIN - 1) / (k + 1) + 1;
  endfunction

  function automatic logic [N-1:0] pat(input int p, input int s);
    logic [N-1:0] v;
    v = '0;
    if (p == 0) return {N{1'b1}};
    for (int k = 0; k < N; k++) begin
      case (k)
        0:       v[k] = (s % 2 == 0);
        1:       v[k] = 1'b0;
        15:      v[k] = (s % 4 == 0);
        default: v[k] = (s % (k + 1) == 0);
      endcase
    end
    return v;
  endfunction

  task automatic drive(input logic st, input logic sv, input logic [N-1:0] b, input logic rdy);
    @(negedge clk);
    bus.start       = st;
    bus.streamValid = sv;
    bus.streams     = b;
    bus.resultReady = rdy;
  endtask

  task automatic run_window(input int p, input bit stall, input bit from_hold,
                            input int start_at, input int abort_at);
    int s;
    int c;
    if (abort_at < 0)
      for (int k = 0; k < N; k++) exp_q.push_back(W'(exp_count(p, k)));
    if (from_hold) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);
      check("b2b_busy", bus.busy, 1'b1);
      check("b2b_cleared", bus.results[0 +: W], '0);
      check("b2b_state", bus.state_dbg, 2'd1);
    end else begin
      drive(1'b1, 1'b1, {N{1'b1}}, 1'b0);
    end
    s = 0;
    c = 0;
    while (s < WIN) begin
      if (abort_at == s) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.start = 1'b0; bus.streamValid = 1'b0; bus.streams = '0; bus.resultReady = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        check("abort_results", bus.results, '0);
        check("abort_valid", bus.resultValid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_state", bus.state_dbg, 2'd0);
        rst_n = 1'b1;
        return;
      end
      if (stall && (c % 3 == 2)) drive(1'b0, 1'b0, {N{1'b1}}, 1'b0);
      else begin
        drive(start_at == s, 1'b1, pat(p, s), 1'b0);
        s++;
      end
      c++;
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    check("rv_latency", bus.resultValid, 1'b1);
    check("hold_busy", bus.busy, 1'b0);
    check("hold_state", bus.state_dbg, 2'd2);
  endtask

  task automatic finish_window();
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("idle_valid", bus.resultValid, 1'b0);
    check("idle_state", bus.state_dbg, 2'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.start = 1'b0; bus.streamValid = 1'b0; bus.streams = '0; bus.resultReady = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_results", bus.results, '0);
    check("rst_valid", bus.resultValid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", bus.state_dbg, 2'd0);
    rst_n = 1'b1;

    // all-ones window
    run_window(0, 1'b0, 1'b0, -1, -1);
    for (int k = 0; k < N; k++) check("t1_word", bus.results[k*W +: W], 9'h100);
    finish_window();
    check("t1_retained", bus.results[0 +: W], 9'h100);

    // mixed patterns
    run_window(1, 1'b0, 1'b0, -1, -1);
    check("t2_s0", bus.results[0 +: W], 9'd128);
    check("t2_s1", bus.results[1*W +: W], 9'd0);
    check("t2_s15", bus.results[15*W +: W], 9'd64);
    finish_window();

    // stalls every third cycle, then backpressure in HOLD
    run_window(1, 1'b1, 1'b0, -1, -1);
    for (int i = 0; i < 10; i++) drive(i == 4, 1'b0, {N{1'b1}}, 1'b0);
    check("bp_valid", bus.resultValid, 1'b1);
    check("bp_s0", bus.results[0 +: W], 9'd128);
    run_window(0, 1'b0, 1'b1, -1, -1);
    finish_window();

    // start pulsed mid-window is ignored
    run_window(1, 1'b0, 1'b0, 100, -1);
    check("t5_s2", bus.results[2*W +: W], 9'd86);
    finish_window();

    // reset at sample 150, then a clean window
    run_window(0, 1'b0, 1'b0, -1, 150);
    run_window(0, 1'b0, 1'b0, -1, -1);
    check("t6_s7", bus.results[7*W +: W], 9'h100);
    finish_window();

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
